// File: rtl/byte_bus_mmio.sv
// byte_bus_mmio
//   Dual-port byte-wide RAM plus MMIO target that sits behind the load/store
//   byte sequencer. Each port decodes its address into RAM, MMIO or unmapped.
//   Reads return one cycle later on recv_data_a/b.
//
//   MMIO map (offset = addr[3:0]):
//     0x0-0x3  LED register, R/W per byte
//     0x4-0x5  synchronised switches, RO; 0x6-0x7 read 0
//     0x8-0xB  cycle counter, RO, little-endian; a read of 0x8 captures a snapshot
//     0xC      error register {7'b0, err_flag}; any write clears err_flag
//     0xD-0xF  read 0, writes ignored
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   en                     access strobe shared by both ports
//   wea, web               per-port write enables (qualified by en)
//   addr_a/b, data_a/b     per-port byte address and write byte
//   recv_data_a/b          per-port registered read byte
//   sw_in                  asynchronous switch inputs
//   led_out                LED register bits [15:0]
//   err_flag               sticky unmapped-access flag
module byte_bus_mmio #(
   parameter int          DEPTH     = 4096,
   parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
   parameter string       INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        wea,
   input  logic        web,
   input  logic [31:0] addr_a,
   input  logic [7:0]  data_a,
   input  logic [31:0] addr_b,
   input  logic [7:0]  data_b,
   output logic [7:0]  recv_data_a,
   output logic [7:0]  recv_data_b,
   input  logic [15:0] sw_in,
   output logic [15:0] led_out,
   output logic        err_flag
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]  mem [DEPTH];

   logic [31:0] led_reg;
   logic [31:0] cycle_cnt;
   logic [31:0] cnt_snap;
   logic [15:0] sw_meta;
   logic [15:0] sw_sync;

   logic        ram_a, ram_b;
   logic        mmio_a, mmio_b;
   logic        unm_a, unm_b;
   logic [3:0]  off_a, off_b;
   logic [AW-1:0] idx_a, idx_b;
   logic        acc;
   logic        wr_a, wr_b;
   logic        cap;
   logic        err_set, err_clr;
   logic [31:0] cnt_view;
   logic [7:0]  mmio_rd_a, mmio_rd_b;

   assign ram_a  = (addr_a < 32'(DEPTH));
   assign ram_b  = (addr_b < 32'(DEPTH));
   assign mmio_a = (addr_a[31:4] == MMIO_BASE[31:4]);
   assign mmio_b = (addr_b[31:4] == MMIO_BASE[31:4]);
   assign unm_a  = !ram_a && !mmio_a;
   assign unm_b  = !ram_b && !mmio_b;
   assign off_a  = addr_a[3:0];
   assign off_b  = addr_b[3:0];
   assign idx_a  = addr_a[AW-1:0];
   assign idx_b  = addr_b[AW-1:0];

   // rst dominates en: nothing is written while reset is held.
   assign acc  = en && !rst;
   assign wr_a = acc && wea;
   assign wr_b = acc && web;

   assign cap = acc && ((mmio_a && off_a == 4'h8) || (mmio_b && off_b == 4'h8));

   // In the capture cycle every counter byte comes from the live value so a
   // multi-byte read in that cycle is coherent with the new snapshot.
   assign cnt_view = cap ? cycle_cnt : cnt_snap;

   assign err_set = acc && (unm_a || unm_b);
   assign err_clr = (wr_a && mmio_a && off_a == 4'hC) ||
                    (wr_b && mmio_b && off_b == 4'hC);

   function automatic logic [7:0] mmio_rd(input logic [3:0]  off,
                                          input logic [31:0] led,
                                          input logic [15:0] sw,
                                          input logic [31:0] cnt,
                                          input logic        err);
      logic [7:0] d;
      d = 8'h00;
      case (off)
         4'h0: d = led[7:0];
         4'h1: d = led[15:8];
         4'h2: d = led[23:16];
         4'h3: d = led[31:24];
         4'h4: d = sw[7:0];
         4'h5: d = sw[15:8];
         4'h8: d = cnt[7:0];
         4'h9: d = cnt[15:8];
         4'hA: d = cnt[23:16];
         4'hB: d = cnt[31:24];
         4'hC: d = {7'b0, err};
         default: d = 8'h00;
      endcase
      return d;
   endfunction

   always_comb begin
      mmio_rd_a = mmio_rd(off_a, led_reg, sw_sync, cnt_view, err_flag);
      mmio_rd_b = mmio_rd(off_b, led_reg, sw_sync, cnt_view, err_flag);
   end

   // Port b is applied last so it wins a same-address collision.
   always_ff @(posedge clk) begin
      if (wr_a && ram_a) mem[idx_a] <= data_a;
      if (wr_b && ram_b) mem[idx_b] <= data_b;
   end

   // Reads sample pre-edge state, so same-cycle writes on either port are
   // not visible (read-first).
   always_ff @(posedge clk) begin
      if (rst) begin
         recv_data_a <= 8'h00;
         recv_data_b <= 8'h00;
      end else if (en) begin
         recv_data_a <= ram_a ? mem[idx_a] : (mmio_a ? mmio_rd_a : 8'h00);
         recv_data_b <= ram_b ? mem[idx_b] : (mmio_b ? mmio_rd_b : 8'h00);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         led_reg <= '0;
      end else begin
         if (wr_a && mmio_a && off_a[3:2] == 2'b00)
            led_reg[{off_a[1:0], 3'b000} +: 8] <= data_a;
         if (wr_b && mmio_b && off_b[3:2] == 2'b00)
            led_reg[{off_b[1:0], 3'b000} +: 8] <= data_b;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt <= '0;
         cnt_snap  <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (cap) cnt_snap <= cycle_cnt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= sw_in;
         sw_sync <= sw_meta;
      end
   end

   // Set wins over a same-cycle clear from the other port.
   always_ff @(posedge clk) begin
      if (rst)          err_flag <= 1'b0;
      else if (err_set) err_flag <= 1'b1;
      else if (err_clr) err_flag <= 1'b0;
   end

   assign led_out = led_reg[15:0];

endmodule
